// File: rtl/sd4_pe_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sd4_pe_pipe
// Purpose  : 3-stage pipelined signed dot-product PE: multiply, adder-tree
//            reduce, arithmetic shift, then add the psum or accumulator.
//            Define PE_SAT_EN to saturate the final add; otherwise it wraps.
// Revision : 1.0 - initial pipelined release
// ============================================================================
module sd4_pe_pipe #(
    parameter int LANES   = 3,
    parameter int IMG_W   = 8,
    parameter int WGT_W   = 12,
    parameter int PSUM_W  = 16,
    parameter int SHIFT_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*IMG_W-1:0]   image_in,
    input  logic [LANES*WGT_W-1:0]   weight,
    input  logic [SHIFT_W-1:0]       exp_bias,
    input  logic [PSUM_W-1:0]        psum,
    input  logic                     acc_mode,
    input  logic                     acc_clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PSUM_W-1:0]        psum_out
);

    localparam int PROD_W = IMG_W + WGT_W;
    localparam int SUM_W  = PROD_W + $clog2(LANES);
    localparam int EXT_W  = ((SUM_W > PSUM_W) ? SUM_W : PSUM_W) + 1;

    logic w_adv;

    // Single global stall: every stage moves together or not at all.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // ------------------------------------------------------------------
    // S1: per-lane signed products
    // ------------------------------------------------------------------
    logic signed [PROD_W-1:0]  w_prod  [LANES];
    logic signed [PROD_W-1:0]  r1_prod [LANES];
    logic                      r1_valid;
    logic [SHIFT_W-1:0]        r1_exp;
    logic signed [PSUM_W-1:0]  r1_psum;
    logic                      r1_mode;
    logic                      r1_clr;

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            logic signed [IMG_W-1:0] w_img;
            logic signed [WGT_W-1:0] w_wgt;
            assign w_img     = image_in[g*IMG_W +: IMG_W];
            assign w_wgt     = weight[g*WGT_W +: WGT_W];
            assign w_prod[g] = w_img * w_wgt;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r1_valid <= 1'b0;
            r1_exp   <= '0;
            r1_psum  <= '0;
            r1_mode  <= 1'b0;
            r1_clr   <= 1'b0;
            for (int i = 0; i < LANES; i++) r1_prod[i] <= '0;
        end else if (w_adv) begin
            r1_valid <= in_valid;
            r1_exp   <= exp_bias;
            r1_psum  <= psum;
            r1_mode  <= acc_mode;
            r1_clr   <= acc_clr;
            for (int i = 0; i < LANES; i++) r1_prod[i] <= w_prod[i];
        end
    end

    // ------------------------------------------------------------------
    // S2: reduction; SUM_W is wide enough that this cannot overflow
    // ------------------------------------------------------------------
    logic signed [SUM_W-1:0]   w_sum;
    logic signed [SUM_W-1:0]   r2_sum;
    logic                      r2_valid;
    logic [SHIFT_W-1:0]        r2_exp;
    logic signed [PSUM_W-1:0]  r2_psum;
    logic                      r2_mode;
    logic                      r2_clr;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < LANES; i++) w_sum = w_sum + SUM_W'(r1_prod[i]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r2_valid <= 1'b0;
            r2_sum   <= '0;
            r2_exp   <= '0;
            r2_psum  <= '0;
            r2_mode  <= 1'b0;
            r2_clr   <= 1'b0;
        end else if (w_adv) begin
            r2_valid <= r1_valid;
            r2_sum   <= w_sum;
            r2_exp   <= r1_exp;
            r2_psum  <= r1_psum;
            r2_mode  <= r1_mode;
            r2_clr   <= r1_clr;
        end
    end

    // ------------------------------------------------------------------
    // S3: shift, add addend, reduce to PSUM_W; accumulator lives here only,
    // so consecutive accumulate beats see each other's results directly.
    // ------------------------------------------------------------------
    logic signed [PSUM_W-1:0]  r_acc;
    logic signed [SUM_W-1:0]   w_shift;
    logic signed [PSUM_W-1:0]  w_addend;
    logic signed [EXT_W-1:0]   w_total;
    logic signed [PSUM_W-1:0]  w_res;

    always_comb begin
        if (int'(r2_exp) >= SUM_W) begin
            w_shift = {SUM_W{r2_sum[SUM_W-1]}};
        end else begin
            w_shift = r2_sum >>> r2_exp;
        end

        w_addend = r2_psum;
        if (r2_mode) begin
            w_addend = r2_clr ? '0 : r_acc;
        end

        w_total = EXT_W'(w_shift) + EXT_W'(w_addend);

`ifdef PE_SAT_EN
        // Fits when all bits from PSUM_W-1 upward agree with the sign.
        if ((w_total >>> (PSUM_W - 1)) == '0 || (w_total >>> (PSUM_W - 1)) == '1) begin
            w_res = PSUM_W'(w_total);
        end else if (w_total[EXT_W-1]) begin
            w_res = {1'b1, {(PSUM_W-1){1'b0}}};
        end else begin
            w_res = {1'b0, {(PSUM_W-1){1'b1}}};
        end
`else
        w_res = PSUM_W'(w_total);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            psum_out  <= '0;
            r_acc     <= '0;
        end else if (w_adv) begin
            out_valid <= r2_valid;
            if (r2_valid) begin
                psum_out <= w_res;
                if (r2_mode) begin
                    r_acc <= w_res;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sd4_pe_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd4_pe_pipe
// Purpose  : Directed self-checking bench for sd4_pe_pipe (either PE_SAT_EN build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd4_pe_pipe;

    localparam int LANES = 3, IMG_W = 8, WGT_W = 12, PSUM_W = 16, SHIFT_W = 5;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*IMG_W-1:0]  image_in;
    logic [LANES*WGT_W-1:0]  weight;
    logic [SHIFT_W-1:0]      exp_bias;
    logic [PSUM_W-1:0]       psum;
    logic                    acc_mode;
    logic                    acc_clr;
    logic                    out_valid;
    logic                    out_ready;
    logic [PSUM_W-1:0]       psum_out;

    sd4_pe_pipe #(
        .LANES(LANES), .IMG_W(IMG_W), .WGT_W(WGT_W), .PSUM_W(PSUM_W), .SHIFT_W(SHIFT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .image_in(image_in), .weight(weight), .exp_bias(exp_bias), .psum(psum),
        .acc_mode(acc_mode), .acc_clr(acc_clr), .out_valid(out_valid),
        .out_ready(out_ready), .psum_out(psum_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Beat table shared by the stream driver
    logic [LANES*IMG_W-1:0] b_img  [8];
    logic [LANES*WGT_W-1:0] b_wgt  [8];
    logic [SHIFT_W-1:0]     b_exp  [8];
    logic [PSUM_W-1:0]      b_psum [8];
    logic                   b_mode [8];
    logic                   b_clr  [8];
    logic [PSUM_W-1:0]      exp_v  [8];
    logic [PSUM_W-1:0]      got    [8];
    int                     n_beats, n_got, acc_first, out_first, acc_at_stall;
    logic                   ready_at_stall, ready_end;

    function automatic logic [LANES*IMG_W-1:0] pimg(input int a, input int b, input int c);
        logic [LANES*IMG_W-1:0] v;
        v = {c[7:0], b[7:0], a[7:0]};
        return v;
    endfunction

    function automatic logic [LANES*WGT_W-1:0] pwgt(input int a, input int b, input int c);
        logic [LANES*WGT_W-1:0] v;
        v = {c[11:0], b[11:0], a[11:0]};
        return v;
    endfunction

    task automatic set_beat(input int i, input logic [LANES*IMG_W-1:0] img,
                            input logic [LANES*WGT_W-1:0] wgt, input int e, input int p,
                            input logic m, input logic cl, input int expect_val);
        b_img[i]  = img;
        b_wgt[i]  = wgt;
        b_exp[i]  = SHIFT_W'(e);
        b_psum[i] = PSUM_W'(p);
        b_mode[i] = m;
        b_clr[i]  = cl;
        exp_v[i]  = PSUM_W'(expect_val);
    endtask

    // Offers b_* beats back to back; holds out_ready low for the first
    // `stall` cycles when stall > 0. Bounded to 60 cycles.
    task automatic run_stream(input int stall);
        int  idx;
        logic took_in;
        idx = 0; n_got = 0; acc_first = -1; out_first = -1;
        acc_at_stall = -1; ready_at_stall = 1'bx;
        for (int i = 0; i < 8; i++) got[i] = 'x;
        out_ready = (stall == 0);
        for (int c = 0; c < 60 && n_got < n_beats; c++) begin
            @(negedge clk);
            if (stall > 0 && c == stall) begin
                acc_at_stall   = idx;
                ready_at_stall = in_ready;
                out_ready      = 1'b1;
            end
            if (idx < n_beats) begin
                in_valid = 1'b1;
                image_in = b_img[idx];  weight  = b_wgt[idx];
                exp_bias = b_exp[idx];  psum    = b_psum[idx];
                acc_mode = b_mode[idx]; acc_clr = b_clr[idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            took_in = in_valid && in_ready;
            if (took_in && acc_first < 0) acc_first = c;
            if (out_valid && out_ready) begin
                if (n_got < 8) got[n_got] = psum_out;
                if (out_first < 0) out_first = c;
                n_got++;
            end
            @(posedge clk);
            if (took_in) idx++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        ready_end = in_ready;
    endtask

    task automatic test_reset;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; image_in = '0; weight = '0;
        exp_bias = '0; psum = '0; acc_mode = 1'b0; acc_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (psum_out !== 16'h0) begin n_err++; $display("FAIL reset_psum_out: got %h want 0000", psum_out); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_dot_basic;
        n_beats = 1;
        set_beat(0, pimg(1, 2, 3), pwgt(4, 5, 6), 0, 15, 1'b0, 1'b0, 47);
        run_stream(0);
        n_cmp++; if (n_got != 1 || got[0] !== exp_v[0]) begin n_err++; $display("FAIL dot_basic: got %0d beats, first %h want 1 beat %h", n_got, got[0], exp_v[0]); end
        n_cmp++; if (out_first - acc_first != 3) begin n_err++; $display("FAIL dot_latency: got %0d cycles want 3", out_first - acc_first); end
    endtask

    task automatic test_shift;
        n_beats = 5;
        set_beat(0, pimg(1, 2, 3),  pwgt(4, 5, 6), 2,  15, 1'b0, 1'b0, 23);
        set_beat(1, pimg(-1, 0, 0), pwgt(5, 0, 0), 1,  0,  1'b0, 1'b0, -3);
        set_beat(2, pimg(1, 2, 3),  pwgt(4, 5, 6), 21, 0,  1'b0, 1'b0, 0);
        set_beat(3, pimg(1, 2, 3),  pwgt(4, 5, 6), 22, 7,  1'b0, 1'b0, 7);
        set_beat(4, pimg(-1, 0, 0), pwgt(5, 0, 0), 31, 0,  1'b0, 1'b0, -1);
        run_stream(0);
        n_cmp++; if (n_got != n_beats) begin n_err++; $display("FAIL shift_count: got %0d want %0d", n_got, n_beats); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (got[i] !== exp_v[i]) begin n_err++; $display("FAIL shift_%0d: got %h want %h", i, got[i], exp_v[i]); end
        end
    endtask

    task automatic test_saturate;
        n_beats = 3;
`ifdef PE_SAT_EN
        set_beat(0, pimg(127, 127, 127),    pwgt(2047, 2047, 2047), 0, 0,     1'b0, 1'b0, 32767);
        set_beat(1, pimg(-128, -128, -128), pwgt(2047, 2047, 2047), 0, 0,     1'b0, 1'b0, -32768);
        set_beat(2, pimg(1, 2, 3),          pwgt(4, 5, 6),          0, 32767, 1'b0, 1'b0, 32767);
`else
        // 779907 mod 2^16 = 0xE683; -786048 mod 2^16 = 0x0180; 32799 wraps to 0x801F
        set_beat(0, pimg(127, 127, 127),    pwgt(2047, 2047, 2047), 0, 0,     1'b0, 1'b0, 'hE683);
        set_beat(1, pimg(-128, -128, -128), pwgt(2047, 2047, 2047), 0, 0,     1'b0, 1'b0, 'h0180);
        set_beat(2, pimg(1, 2, 3),          pwgt(4, 5, 6),          0, 32767, 1'b0, 1'b0, 'h801F);
`endif
        run_stream(0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (got[i] !== exp_v[i]) begin n_err++; $display("FAIL sat_%0d: got %h want %h", i, got[i], exp_v[i]); end
        end
    endtask

    task automatic test_stall;
        n_beats = 5;
        for (int k = 0; k < 5; k++) set_beat(k, pimg(k + 1, 0, 0), pwgt(1, 0, 0), 0, 0, 1'b0, 1'b0, k + 1);
        run_stream(6);
        n_cmp++; if (acc_at_stall != 3) begin n_err++; $display("FAIL stall_accepted: got %0d want 3", acc_at_stall); end
        n_cmp++; if (ready_at_stall !== 1'b0) begin n_err++; $display("FAIL stall_in_ready: got %b want 0", ready_at_stall); end
        n_cmp++; if (n_got != 5) begin n_err++; $display("FAIL stall_count: got %0d want 5", n_got); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (got[i] !== exp_v[i]) begin n_err++; $display("FAIL stall_order_%0d: got %h want %h", i, got[i], exp_v[i]); end
        end
        n_cmp++; if (ready_end !== 1'b1) begin n_err++; $display("FAIL stall_ready_return: got %b want 1", ready_end); end
    endtask

    task automatic test_back_to_back_acc;
        n_beats = 5;
        set_beat(0, pimg(1, 2, 3), pwgt(4, 5, 6), 0, 0,   1'b1, 1'b1, 32);
        set_beat(1, pimg(1, 2, 3), pwgt(4, 5, 6), 0, 999, 1'b1, 1'b0, 64);
        set_beat(2, pimg(1, 2, 3), pwgt(4, 5, 6), 0, 999, 1'b1, 1'b0, 96);
        set_beat(3, pimg(1, 2, 3), pwgt(4, 5, 6), 0, 15,  1'b0, 1'b1, 47);
        set_beat(4, pimg(0, 0, 0), pwgt(0, 0, 0), 0, 999, 1'b1, 1'b0, 96);
        run_stream(0);
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (got[i] !== exp_v[i]) begin n_err++; $display("FAIL acc_%0d: got %0d want %0d", i, $signed(got[i]), $signed(exp_v[i])); end
        end
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1; image_in = pimg(1, 2, 3); weight = pwgt(4, 5, 6);
            exp_bias = '0; psum = '0; acc_mode = 1'b1; acc_clr = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (psum_out !== 16'h0) begin n_err++; $display("FAIL midreset_psum_out: got %h want 0000", psum_out); end
        @(negedge clk);
        rst = 1'b1;
        n_beats = 1;
        set_beat(0, pimg(1, 2, 3), pwgt(4, 5, 6), 0, 0, 1'b1, 1'b0, 32);
        run_stream(0);
        n_cmp++; if (n_got != 1 || got[0] !== exp_v[0]) begin n_err++; $display("FAIL midreset_acc_cleared: got %0d beats, first %0d want 1 beat 32", n_got, $signed(got[0])); end
    endtask

    initial begin
        test_reset();
        test_dot_basic();
        test_shift();
        test_saturate();
        test_stall();
        test_back_to_back_acc();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
